// File: rtl/traffic_grid_pkg.sv
// traffic_grid_pkg: FSM encoding, LFSR constants and the clog2 helper shared by traffic_grid and traffic_lane
package traffic_grid_pkg;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] SEED_ZERO = 8'hA5;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/traffic_lane.sv
// traffic_lane: one lane of cells with rule lookup, Galois LFSR stall, serial-load write port and exit detection
//   i_step: advance one generation      i_seed_ld/i_seed: load LFSR (seed^LANE, zero -> A5)
//   i_rule/i_open: rule table, open boundary     i_stall: stall threshold
//   i_wr_en/i_wr_idx/i_wr_bit: global-index load write     o_cells: row, o_nxt: row after this edge
//   o_exit: car left cell W-1 in this step
module traffic_lane
    import traffic_grid_pkg::*;
#(
    parameter int W    = 30,
    parameter int IW   = 8,
    parameter int LANE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_step,
    input  logic          i_seed_ld,
    input  logic [7:0]    i_seed,
    input  logic [7:0]    i_rule,
    input  logic          i_open,
    input  logic [7:0]    i_stall,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_idx,
    input  logic          i_wr_bit,
    output logic [W-1:0]  o_cells,
    output logic [W-1:0]  o_nxt,
    output logic          o_exit
);
    logic [W-1:0] r_cells, w_gen;
    logic [7:0]   r_lfsr, w_seed;
    logic         w_move;

    assign w_seed  = i_seed ^ 8'(LANE);
    // LFSR never holds zero, so threshold 0 can never stall
    assign w_move  = i_step && !(r_lfsr <= i_stall);
    assign o_cells = r_cells;
    assign o_exit  = w_move && r_cells[W-1] && !w_gen[W-1];

    for (genvar x = 0; x < W; x++) begin : g_cell
        logic w_l, w_r;
        assign w_l      = (i_open && x == 0) ? 1'b0 : r_cells[(x + W - 1) % W];
        assign w_r      = (i_open && x == W - 1) ? 1'b0 : r_cells[(x + 1) % W];
        assign w_gen[x] = i_rule[{w_l, r_cells[x], w_r}];
        assign o_nxt[x] = (i_wr_en && i_wr_idx == IW'(LANE * W + x)) ? i_wr_bit :
                          w_move ? w_gen[x] : r_cells[x];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cells <= '0;
            r_lfsr  <= SEED_ZERO;
        end else begin
            r_cells <= o_nxt;
            r_lfsr  <= i_seed_ld ? (w_seed == 8'h00 ? SEED_ZERO : w_seed) :
                       i_step ? ({1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 8'h00)) : r_lfsr;
        end
    end
endmodule

// File: rtl/traffic_grid.sv
// traffic_grid: GRID_HEIGHT independent cellular-automaton traffic lanes with serial load and stepped runs
//   init/cell_init_status_in: serial load, lane 0 cell 0 first     start/number_of_steps: begin a run
//   rule_in, boundary_mode, stall_chance_in, cell_lfsr_seed_in: run configuration
//   grid_state, occupancy, flow_total: results     busy, step_valid, done: status
module traffic_grid
    import traffic_grid_pkg::*;
#(
    parameter int GRID_WIDTH  = 30,
    parameter int GRID_HEIGHT = 3,
    parameter int STEP_W      = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          init,
    input  logic                                          cell_init_status_in,
    input  logic                                          start,
    input  logic [STEP_W-1:0]                             number_of_steps,
    input  logic [7:0]                                    rule_in,
    input  logic                                          boundary_mode,
    input  logic [7:0]                                    stall_chance_in,
    input  logic [7:0]                                    cell_lfsr_seed_in,
    output logic [GRID_WIDTH*GRID_HEIGHT-1:0]             grid_state,
    output logic                                          busy,
    output logic                                          step_valid,
    output logic [clog2(GRID_WIDTH*GRID_HEIGHT+1)-1:0]    occupancy,
    output logic [STEP_W-1:0]                             flow_total,
    output logic                                          done
);
    localparam int N  = GRID_WIDTH * GRID_HEIGHT;
    localparam int OW = clog2(N + 1);

    state_t              r_state, w_state_nxt;
    logic [OW-1:0]       r_ld_cnt, w_pop, w_wr_idx;
    logic [STEP_W-1:0]   r_steps, r_cnt, r_flow;
    logic [STEP_W:0]     w_sum;
    logic [N-1:0]        w_nxt;
    logic [GRID_HEIGHT-1:0] w_exit;
    logic                r_open, r_sv, w_step, w_start, w_wr;

    assign w_step     = r_state == S_RUN && !init;
    assign w_start    = start && !init && (r_state == S_IDLE || r_state == S_DONE);
    // the first init cycle writes cell 0, so the counter restarts on LOAD entry
    assign w_wr_idx   = r_state == S_LOAD ? r_ld_cnt : '0;
    assign w_wr       = init && (r_state != S_LOAD || r_ld_cnt < OW'(N));
    assign busy       = r_state == S_LOAD || r_state == S_RUN;
    assign done       = r_state == S_DONE;
    assign step_valid = r_sv;
    assign flow_total = r_flow;

    for (genvar l = 0; l < GRID_HEIGHT; l++) begin : g_lane
        traffic_lane #(.W(GRID_WIDTH), .IW(OW), .LANE(l)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_step    (w_step),
            .i_seed_ld (w_start),
            .i_seed    (cell_lfsr_seed_in),
            .i_rule    (rule_in),
            .i_open    (r_open),
            .i_stall   (stall_chance_in),
            .i_wr_en   (w_wr),
            .i_wr_idx  (w_wr_idx),
            .i_wr_bit  (cell_init_status_in),
            .o_cells   (grid_state[l*GRID_WIDTH +: GRID_WIDTH]),
            .o_nxt     (w_nxt[l*GRID_WIDTH +: GRID_WIDTH]),
            .o_exit    (w_exit[l])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N; i++) w_pop = w_pop + OW'(w_nxt[i]);
        w_sum = {1'b0, r_flow};
        for (int i = 0; i < GRID_HEIGHT; i++) w_sum = w_sum + (STEP_W + 1)'(w_exit[i]);
    end

    always_comb begin
        w_state_nxt = r_state;
        if (init)
            w_state_nxt = S_LOAD;
        else if (r_state == S_LOAD)
            w_state_nxt = S_IDLE;
        else if (w_start)
            w_state_nxt = number_of_steps == '0 ? S_DONE : S_RUN;
        else if (w_step && r_cnt + STEP_W'(1) == r_steps)
            w_state_nxt = S_DONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_ld_cnt <= '0;
            r_steps  <= '0;
            r_cnt    <= '0;
            r_flow   <= '0;
            r_open   <= 1'b0;
            r_sv     <= 1'b0;
            occupancy <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sv      <= w_step;
            occupancy <= w_pop;
            if (init)
                r_ld_cnt <= r_state != S_LOAD ? OW'(1) : (w_wr ? r_ld_cnt + OW'(1) : r_ld_cnt);
            if (w_start) begin
                r_steps <= number_of_steps;
                r_cnt   <= '0;
                r_flow  <= '0;
                r_open  <= boundary_mode;
            end else if (w_step) begin
                r_cnt  <= r_cnt + STEP_W'(1);
                r_flow <= w_sum[STEP_W] ? '1 : w_sum[STEP_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_traffic_grid.sv
// tb_traffic_grid: directed vectors for traffic_grid (8 cells x 2 lanes, rule 184)
module tb_traffic_grid;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init = 1'b0;
    logic        cell_init_status_in = 1'b0;
    logic        start = 1'b0;
    logic [31:0] number_of_steps = '0;
    logic [7:0]  rule_in = 8'hB8;
    logic        boundary_mode = 1'b0;
    logic [7:0]  stall_chance_in = 8'h00;
    logic [7:0]  cell_lfsr_seed_in = 8'h5A;
    logic [15:0] grid_state;
    logic        busy, step_valid, done;
    logic [4:0]  occupancy;
    logic [31:0] flow_total;

    int n_chk = 0;
    int n_pass = 0;
    int sv_cnt, busy_lo;

    traffic_grid #(.GRID_WIDTH(8), .GRID_HEIGHT(2), .STEP_W(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .init                (init),
        .cell_init_status_in (cell_init_status_in),
        .start               (start),
        .number_of_steps     (number_of_steps),
        .rule_in             (rule_in),
        .boundary_mode       (boundary_mode),
        .stall_chance_in     (stall_chance_in),
        .cell_lfsr_seed_in   (cell_lfsr_seed_in),
        .grid_state          (grid_state),
        .busy                (busy),
        .step_valid          (step_valid),
        .occupancy           (occupancy),
        .flow_total          (flow_total),
        .done                (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // drives nb bits LSB first; counts step_valid pulses and busy-low cycles seen while loading
    task automatic load(input logic [31:0] g, input int nb);
        sv_cnt  = 0;
        busy_lo = 0;
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            if (k > 0) begin
                sv_cnt  += int'(step_valid);
                busy_lo += int'(!busy);
            end
            init = 1'b1;
            cell_init_status_in = g[k];
        end
        @(negedge clk);
        sv_cnt  += int'(step_valid);
        busy_lo += int'(!busy);
        init = 1'b0;
        @(negedge clk);
    endtask

    task automatic run(input logic [31:0] n, input logic bm, input logic [7:0] st, input logic [7:0] seed);
        int k;
        @(negedge clk);
        number_of_steps = n;
        boundary_mode = bm;
        stall_chance_in = st;
        cell_lfsr_seed_in = seed;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sv_cnt = int'(step_valid);
        chk("done_after_start", done, n == 0);
        k = 0;
        while (!done && k < 200) begin
            @(negedge clk);
            sv_cnt += int'(step_valid);
            k++;
        end
        @(negedge clk);
        sv_cnt += int'(step_valid);
        chk("done_level", done, 1);
    endtask

    initial begin
        #12;
        chk("rst_grid", grid_state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_flow", flow_total, 0);
        chk("rst_sv", step_valid, 0);
        @(negedge clk);
        rst = 1'b1;

        load(32'h0001, 16);
        chk("t1_load_grid", grid_state, 16'h0001);
        chk("t1_load_occ", occupancy, 1);
        chk("t1_load_busy", busy_lo, 0);
        chk("t1_idle_busy", busy, 0);
        run(5, 1'b0, 8'h00, 8'h5A);
        chk("t1_sv", sv_cnt, 5);
        chk("t1_grid", grid_state, 16'h0020);
        chk("t1_occ", occupancy, 1);
        chk("t1_flow", flow_total, 0);

        load(32'h0080, 16);
        run(1, 1'b0, 8'h00, 8'h5A);
        chk("t2_grid", grid_state, 16'h0001);
        chk("t2_flow", flow_total, 1);
        chk("t2_sv", sv_cnt, 1);

        load(32'h0080, 16);
        run(1, 1'b1, 8'h00, 8'h5A);
        chk("t3_grid", grid_state, 16'h0000);
        chk("t3_occ", occupancy, 0);
        chk("t3_flow", flow_total, 1);

        load(32'h00C0, 16);
        run(2, 1'b1, 8'h00, 8'h5A);
        chk("t3b_grid", grid_state, 16'h0080);
        chk("t3b_flow", flow_total, 1);

        load(32'hF3CA5, 20);
        chk("t4_load_extra", grid_state, 16'h3CA5);
        run(4, 1'b0, 8'hFF, 8'h5A);
        chk("t4_grid", grid_state, 16'h3CA5);
        chk("t4_flow", flow_total, 0);
        chk("t4_sv", sv_cnt, 4);
        chk("t4_occ", occupancy, 8);

        run(0, 1'b0, 8'h00, 8'h5A);
        chk("t5_grid", grid_state, 16'h3CA5);
        chk("t5_sv", sv_cnt, 0);

        load(32'h0801, 16);
        run(5, 1'b0, 8'h00, 8'h5A);
        chk("t6_grid", grid_state, 16'h0120);
        chk("t6_flow", flow_total, 1);
        chk("t6_occ", occupancy, 2);

        load(32'h0101, 16);
        run(3, 1'b0, 8'h01, 8'h01);
        chk("t7_lfsr_grid", grid_state, 16'h0804);

        load(32'h0001, 16);
        @(negedge clk);
        number_of_steps = 10;
        stall_chance_in = 8'h00;
        boundary_mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sv_cnt = 0;
        for (int k = 0; k < 20 && sv_cnt < 3; k++) begin
            @(negedge clk);
            sv_cnt += int'(step_valid);
        end
        chk("t8_pre_grid", grid_state, 16'h0008);
        load(32'h0002, 16);
        chk("t8_abort_sv", sv_cnt, 0);
        chk("t8_abort_busy", busy_lo, 0);
        chk("t8_grid", grid_state, 16'h0002);
        chk("t8_done", done, 0);
        chk("t8_idle", busy, 0);

        load(32'h0001, 16);
        @(negedge clk);
        number_of_steps = 10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t9_grid", grid_state, 0);
        chk("t9_busy", busy, 0);
        chk("t9_sv", step_valid, 0);
        chk("t9_occ", occupancy, 0);
        chk("t9_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t9_after_busy", busy, 0);
        chk("t9_after_grid", grid_state, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
